// File: rtl/pll_phase_ctrl_pkg.sv
// Shared types and helpers for the PLL fine-phase sequencer.
//   - ctrl_state_e  : top-level sequencer states
//   - pulse_state_e : PHASESTEP pulse-train states (high / low halves of a step)
//   - SEL_* / DIR_* : PHASESEL and PHASEDIR encodings
//   - phase_mod()   : add/subtract two phase indices modulo NUM_STEPS
package pll_phase_pkg;

    localparam int NUM_STEPS = 24;  // phase positions per output period
    localparam int PW        = 5;   // width of a phase index

    localparam logic [PW-1:0] N_PW    = PW'(NUM_STEPS);
    localparam logic [PW-1:0] HALF_PW = PW'(NUM_STEPS / 2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_SETUP,
        ST_STEP,
        ST_SETTLE
    } ctrl_state_e;

    typedef enum logic [1:0] {
        PS_IDLE,
        PS_HI,
        PS_LO
    } pulse_state_e;

    localparam logic [1:0] SEL_CLKOS  = 2'd0;
    localparam logic [1:0] SEL_CLKOS2 = 2'd1;
    localparam logic [1:0] SEL_CLKOS3 = 2'd2;
    localparam logic [1:0] SEL_CLKOP  = 2'd3;

    localparam logic DIR_FWD = 1'b0;  // index +1
    localparam logic DIR_REV = 1'b1;  // index -1

    // (a + b) or (a - b) modulo NUM_STEPS; both operands must already be < NUM_STEPS.
    function automatic logic [PW-1:0] phase_mod(input logic [PW-1:0] a,
                                                input logic [PW-1:0] b,
                                                input logic          sub);
        logic [PW:0] n_w;
        logic [PW:0] t;
        n_w = (PW+1)'(NUM_STEPS);
        if (sub) begin
            t = (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + n_w - {1'b0, b});
        end else begin
            t = {1'b0, a} + {1'b0, b};
            if (t >= n_w) t = t - n_w;
        end
        return PW'(t);
    endfunction

endpackage

// File: rtl/pll_phase_ctrl_if.sv
// Phase-request handshake between the host command decoder (master) and the
// sequencer (slave). A request transfers on a clock where req_valid & req_ready.
//   req_valid  master->slave  request valid
//   req_ready  slave->master  sequencer idle and able to take a request
//   req_sel    master->slave  PLL output select (SEL_* codes)
//   req_phase  master->slave  target phase index
interface pll_phase_ctrl_if;
    import pll_phase_pkg::*;

    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_sel;
    logic [PW-1:0] req_phase;

    modport master (output req_valid, output req_sel, output req_phase, input req_ready);
    modport slave  (input req_valid, input req_sel, input req_phase, output req_ready);

endinterface

// File: rtl/pll_phase_pulse.sv
// PHASESTEP pulse-train generator: after start, emits n pulses, each STEP_HI
// cycles high followed by STEP_LO cycles low.
//   clk, rst    clock, synchronous active-high reset
//   start       launch a train of n pulses (honoured only while idle)
//   n           number of pulses
//   step        PHASESTEP level
//   step_done   strobe in the last high cycle of each pulse
//   train_done  strobe in the last low cycle of the final pulse
//   idle        no train in progress
module pll_phase_pulse
    import pll_phase_pkg::*;
#(
    parameter int STEP_HI = 2,
    parameter int STEP_LO = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [PW-1:0] n,
    output logic          step,
    output logic          step_done,
    output logic          train_done,
    output logic          idle
);

    localparam int CW = $clog2(((STEP_HI > STEP_LO) ? STEP_HI : STEP_LO) + 1);
    localparam logic [CW-1:0] HI_LAST = CW'(STEP_HI - 1);
    localparam logic [CW-1:0] LO_LAST = CW'(STEP_LO - 1);

    pulse_state_e  ps_q, ps_d;
    logic [CW-1:0] cnt_q;
    logic [PW-1:0] left_q;  // pulses still to be completed

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        ps_d       = ps_q;
        step_done  = 1'b0;
        train_done = 1'b0;
        unique case (ps_q)
            PS_IDLE: if (start && n != '0) ps_d = PS_HI;
            PS_HI: begin
                if (cnt_q == HI_LAST) begin
                    step_done = 1'b1;
                    ps_d      = PS_LO;
                end
            end
            PS_LO: begin
                if (cnt_q == LO_LAST) begin
                    if (left_q == '0) begin
                        train_done = 1'b1;
                        ps_d       = PS_IDLE;
                    end else begin
                        ps_d = PS_HI;
                    end
                end
            end
            default: ps_d = PS_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ps_q   <= PS_IDLE;
            cnt_q  <= '0;
            left_q <= '0;
        end else begin
            ps_q <= ps_d;
            if (ps_d != ps_q)        cnt_q <= '0;
            else if (ps_q != PS_IDLE) cnt_q <= cnt_q + 1'b1;
            if (ps_q == PS_IDLE && start) left_q <= n;
            else if (step_done)           left_q <= left_q - 1'b1;
        end
    end

    assign step = (ps_q == PS_HI);
    assign idle = (ps_q == PS_IDLE);

endmodule

// File: rtl/pll_phase_ctrl.sv
// PLL dynamic fine-phase sequencer. Takes a target phase for one of four PLL
// outputs, steps PHASESTEP along the shortest path, then waits for a stable lock.
// Tracks the current phase of all four outputs.
//   clk, rst    CLKOP clock, synchronous active-high reset
//   req         request handshake (slave side)
//   pll_lock    PLL LOCK, already synchronous to clk
//   phasesel    PLL PHASESEL[1:0]
//   phasedir    PLL PHASEDIR (DIR_FWD / DIR_REV)
//   phasestep   PLL PHASESTEP
//   cur_phase   tracked phase of the last-accepted output select
//   busy        sequencer not idle
//   done / err  one-cycle completion / failure pulses
module pll_phase_ctrl
    import pll_phase_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int STEP_HI   = 2,
    parameter int STEP_LO   = 2,
    parameter int LOCK_WAIT = 16,
    parameter int TIMEOUT   = 4096
) (
    input  logic                clk,
    input  logic                rst,
    pll_phase_ctrl_if.slave     req,
    input  logic                pll_lock,
    output logic [1:0]          phasesel,
    output logic                phasedir,
    output logic                phasestep,
    output logic [PW-1:0]       cur_phase,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int SW = $clog2(SETUP_CYC + 1);
    localparam int LW = $clog2(LOCK_WAIT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] SETUP_LAST = SW'(SETUP_CYC - 1);
    localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCK_WAIT - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

    ctrl_state_e   state_q, state_d;
    logic [1:0]    sel_q;
    logic [PW-1:0] tgt_q;
    logic [PW-1:0] n_q;
    logic [PW-1:0] table_q [4];
    logic [SW-1:0] setup_cnt;
    logic [LW-1:0] lock_cnt;
    logic [TW-1:0] tmo_cnt;

    logic          accept, reject, load, start, fin_ok, fin_err;
    logic [PW-1:0] d, calc_n;
    logic          calc_dir;
    logic          step_done, train_done, pulse_idle;

    pll_phase_pulse #(.STEP_HI(STEP_HI), .STEP_LO(STEP_LO)) u_pulse (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .n          (n_q),
        .step       (phasestep),
        .step_done  (step_done),
        .train_done (train_done),
        .idle       (pulse_idle)
    );

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        reject  = 1'b0;
        load    = 1'b0;
        start   = 1'b0;
        fin_ok  = 1'b0;
        fin_err = 1'b0;
        // Shortest path: forward up to and including half a period, else reverse.
        d        = phase_mod(tgt_q, table_q[sel_q], 1'b1);
        calc_dir = (d <= HALF_PW) ? DIR_FWD : DIR_REV;
        calc_n   = (calc_dir == DIR_FWD) ? d : phase_mod('0, d, 1'b1);
        unique case (state_q)
            ST_IDLE: begin
                if (req.req_valid) begin
                    accept = 1'b1;
                    if (req.req_phase >= N_PW || !pll_lock) reject  = 1'b1;
                    else                                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                if (d == '0) begin
                    fin_ok  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    load    = 1'b1;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (setup_cnt == SETUP_LAST && pulse_idle) begin
                    start   = 1'b1;
                    state_d = ST_STEP;
                end
            end
            ST_STEP: if (train_done) state_d = ST_SETTLE;
            ST_SETTLE: begin
                if (pll_lock && lock_cnt == LOCK_LAST) begin
                    fin_ok  = 1'b1;
                    state_d = ST_IDLE;
                end else if (tmo_cnt == TMO_LAST) begin
                    fin_err = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sel_q     <= SEL_CLKOS;
            tgt_q     <= '0;
            n_q       <= '0;
            phasesel  <= SEL_CLKOS;
            phasedir  <= DIR_FWD;
            setup_cnt <= '0;
            lock_cnt  <= '0;
            tmo_cnt   <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            // NOTE: the phase table is architectural state that must read zero after reset, so every entry is cleared.
            for (int i = 0; i < 4; i++) table_q[i] <= '0;
        end else begin
            state_q <= state_d;
            done    <= fin_ok;
            err     <= reject | fin_err;
            if (accept) begin
                sel_q <= req.req_sel;
                tgt_q <= req.req_phase;
            end
            // PHASESEL/PHASEDIR are loaded once per move and held through SETTLE.
            if (load) begin
                n_q       <= calc_n;
                phasesel  <= sel_q;
                phasedir  <= calc_dir;
                setup_cnt <= '0;
            end else if (state_q == ST_SETUP) begin
                setup_cnt <= setup_cnt + 1'b1;
            end
            if (step_done) table_q[sel_q] <= phase_mod(table_q[sel_q], PW'(1), phasedir);
            // Lock counter needs consecutive lock cycles; the timeout runs regardless.
            if (state_q == ST_SETTLE) begin
                lock_cnt <= pll_lock ? lock_cnt + 1'b1 : '0;
                tmo_cnt  <= tmo_cnt + 1'b1;
            end else begin
                lock_cnt <= '0;
                tmo_cnt  <= '0;
            end
        end
    end

    assign req.req_ready = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign cur_phase     = table_q[sel_q];

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Scoreboard bench for pll_phase_ctrl: directed requests push hand-computed
// expectations; a negedge monitor counts PHASESTEP pulses and checks each
// completion (kind, pulse count, direction/select, cur_phase, latency).
module tb_pll_phase_ctrl;
    import pll_phase_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          pll_lock;
    logic [1:0]    phasesel;
    logic          phasedir;
    logic          phasestep;
    logic [PW-1:0] cur_phase;
    logic          busy, done, err;

    pll_phase_ctrl_if ifc ();

    pll_phase_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req       (ifc),
        .pll_lock  (pll_lock),
        .phasesel  (phasesel),
        .phasedir  (phasedir),
        .phasestep (phasestep),
        .cur_phase (cur_phase),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        int          n;
        bit          dir;
        logic [1:0]  sel;
        logic [PW-1:0] cur;
        int          lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   acc_cyc  = 0;
    int   step_cnt = 0;
    bit   prev_step = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            step_cnt  = 0;
            prev_step = 1'b0;
        end else begin
            if (ifc.req_valid && ifc.req_ready) acc_cyc = cyc;
            if (phasestep) begin
                if (sb.size() == 0) begin
                    check("step_without_request", sb.size(), 1);
                end else begin
                    check("phasesel_during_step", phasesel, sb[0].sel);
                    check("phasedir_during_step", phasedir, sb[0].dir);
                end
                if (!prev_step) step_cnt++;
            end
            prev_step = phasestep;
            if (done || err) begin
                if (sb.size() == 0) begin
                    check("completion_without_request", sb.size(), 1);
                end else begin
                    mon_e = sb.pop_front();
                    check("completion_is_err", err, mon_e.is_err);
                    check("completion_is_done", done, !mon_e.is_err);
                    check("step_count", step_cnt, mon_e.n);
                    check("cur_phase", cur_phase, mon_e.cur);
                    check("latency", cyc - acc_cyc, mon_e.lat);
                    check("ready_at_completion", ifc.req_ready, 1);
                end
                step_cnt = 0;
            end
        end
    end

    // Present one request for one cycle; DUT must be idle when called.
    task automatic issue(input logic [1:0] s, input logic [PW-1:0] p, input bit e_err,
                         input int e_n, input bit e_dir, input logic [PW-1:0] e_cur, input int e_lat);
        exp_t e;
        e.is_err = e_err; e.n = e_n; e.dir = e_dir; e.sel = s; e.cur = e_cur; e.lat = e_lat;
        sb.push_back(e);
        ifc.req_sel   = s;
        ifc.req_phase = p;
        ifc.req_valid = 1'b1;
        @(posedge clk); #1;
        ifc.req_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        if (sb.size() != 0) begin
            check("completion_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst = 1'b1; pll_lock = 1'b1;
        ifc.req_valid = 1'b0; ifc.req_sel = SEL_CLKOS; ifc.req_phase = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("reset_req_ready", ifc.req_ready, 1);
        check("reset_phasesel", phasesel, 0);
        check("reset_phasedir", phasedir, 0);
        check("reset_phasestep", phasestep, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        check("reset_cur_phase", cur_phase, 0);

        // Forward move 0 -> 5, then reverse moves including a 0 -> 23 wrap.
        issue(SEL_CLKOS, 5'd5, 0, 5, DIR_FWD, 5'd5, 40);   wait_done(200);
        issue(SEL_CLKOS, 5'd2, 0, 3, DIR_REV, 5'd2, 32);   wait_done(200);
        issue(SEL_CLKOS, 5'd20, 0, 6, DIR_REV, 5'd20, 44); wait_done(200);

        // Rejections: out-of-range target, and lock low at request time.
        issue(SEL_CLKOS, 5'd30, 1, 0, DIR_FWD, 5'd20, 1);  wait_done(20);
        pll_lock = 1'b0;
        issue(SEL_CLKOS, 5'd7, 1, 0, DIR_FWD, 5'd20, 1);
        pll_lock = 1'b1;
        wait_done(20);

        // Lock timeout after two forward steps: 4 + 2*4 + 4096.
        issue(SEL_CLKOS, 5'd22, 1, 2, DIR_FWD, 5'd22, 4108);
        pll_lock = 1'b0;
        wait_done(5000);
        pll_lock = 1'b1;

        // One step; lock drops for one cycle at SETTLE index 10 -> 8 + 11 + 16.
        issue(SEL_CLKOS, 5'd23, 0, 1, DIR_FWD, 5'd23, 35);
        repeat (17) @(posedge clk);
        #1 pll_lock = 1'b0;
        @(posedge clk); #1 pll_lock = 1'b1;
        wait_done(200);

        // Reset during the third pulse of a 23 -> 4 forward move.
        issue(SEL_CLKOS, 5'd4, 0, 5, DIR_FWD, 5'd4, 40);
        k = 0;
        while (step_cnt < 3 && k < 200) begin
            @(negedge clk); #1;
            k++;
        end
        check("third_step_reached", step_cnt, 3);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_phasestep_drop", phasestep, 0);
        check("rst_busy", busy, 0);
        check("rst_cur_phase", cur_phase, 0);
        check("rst_req_ready", ifc.req_ready, 1);
        sb.delete();
        @(posedge clk); #1 rst = 1'b0;

        // Tables cleared: sel 0 already at 0.
        issue(SEL_CLKOS, 5'd0, 0, 0, DIR_FWD, 5'd0, 2);    wait_done(20);

        // Requests while busy are not accepted.
        issue(SEL_CLKOP, 5'd4, 0, 4, DIR_FWD, 5'd4, 36);
        repeat (4) @(posedge clk);
        #1;
        ifc.req_sel = SEL_CLKOS2; ifc.req_phase = 5'd9; ifc.req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("ready_while_busy", ifc.req_ready, 0);
            @(posedge clk); #1;
        end
        ifc.req_valid = 1'b0;
        wait_done(200);

        // Same phase as current -> done, no steps.
        issue(SEL_CLKOP, 5'd4, 0, 0, DIR_FWD, 5'd4, 2);    wait_done(20);

        // Interleaved selects, ties at half period go forward, wraps both ways.
        issue(SEL_CLKOS, 5'd7, 0, 7, DIR_FWD, 5'd7, 48);     wait_done(200);
        issue(SEL_CLKOP, 5'd16, 0, 12, DIR_FWD, 5'd16, 68);  wait_done(200);
        issue(SEL_CLKOS, 5'd1, 0, 6, DIR_REV, 5'd1, 44);     wait_done(200);
        issue(SEL_CLKOP, 5'd4, 0, 12, DIR_FWD, 5'd4, 68);    wait_done(200);
        issue(SEL_CLKOS3, 5'd23, 0, 1, DIR_REV, 5'd23, 24);  wait_done(200);
        issue(SEL_CLKOS2, 5'd12, 0, 12, DIR_FWD, 5'd12, 68); wait_done(200);
        issue(SEL_CLKOS, 5'd1, 0, 0, DIR_FWD, 5'd1, 2);      wait_done(20);

        repeat (4) @(posedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
